mrd_fsm_ctrl_p4: RTL

// - Top-level sequencer for the mixed-radix DFT memory engine (4 samples/clk).
// - Drives the shared fsm/fsm_r state bus read by the sink, rd/wr and source blocks.
// - Sequence per frame: Sink -> N x (Wait_to_rd -> Rd -> Wait_wr_end) -> Source, N = radix stages.

---
 rtl/mrd_mem_pkt.sv | 25 ++
 rtl/mrd_nstage_cnt.sv | 29 ++
 rtl/mrd_fsm_ctrl_p4.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mrd_mem_pkt.sv
// Purpose: shared state codes, stage-count type and frame limits for the mixed-radix DFT memory sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state_t (Idle..Source codes seen on the fsm/fsm_r bus), NF_MAX, nstage_t, nf_vec_t.
package mrd_mem_pkt;

  localparam int NF_MAX = 6;
  localparam int BEAT_W = 12;

  // Codes are visible to the sink, rd/wr and source blocks, so they are fixed.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SINK    = 3'd1,
    S_WAIT_RD = 3'd2,
    S_RD      = 3'd3,
    S_WAIT_WR = 3'd4,
    S_SOURCE  = 3'd5
  } state_t;

  typedef logic [2:0] nstage_t;

  // Element 0 holds N1, element 5 holds N6.
  typedef logic [NF_MAX-1:0][2:0] nf_vec_t;

endpackage

// File: rtl/mrd_nstage_cnt.sv
// Purpose: count leading nonzero radices in the Nf list (number of DFT stages).
// Latency: combinational.
// Backpressure: none.
// Ports: nf (in, radices N1..N6, 0 terminates the list), n_stg (out, 0..NF_MAX).
module mrd_nstage_cnt
  import mrd_mem_pkt::*;
(
  input  nf_vec_t nf,
  output nstage_t n_stg
);

  logic stop;

  // A zero entry ends the list; anything after it is ignored even if nonzero.
  always_comb begin
    n_stg = '0;
    stop  = 1'b0;
    for (int i = 0; i < NF_MAX; i++) begin
      if (!stop) begin
        if (nf[i] != 3'd0) begin
          n_stg = n_stg + nstage_t'(1);
        end else begin
          stop = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mrd_fsm_ctrl_p4.sv
// Purpose: frame sequencer for the 4-sample/clk mixed-radix DFT memory engine (Sink -> N x (Wait_to_rd -> Rd -> Wait_wr_end) -> Source).
// Latency: 1 clk from any end pulse / eop to the state change; rd_start on the same edge as Rd entry.
// Backpressure: in_ready high only in Idle/Sink; input beats outside those states are not accepted.
// Ports: clk, rst_n (async active-low); in_sop/in_valid/in_eop/in_ready input framing; Nf, dftpts frame config
//        (sampled at sop); rd_end, wr_end, source_end completion pulses; fsm, fsm_r, stage_idx, rd_start,
//        frame_err, wdog_to status.
// Optional: define MRD_WDOG_EN to enable the per-state watchdog (WDOG_CYC cycles); otherwise wdog_to is 0.
module mrd_fsm_ctrl_p4
  import mrd_mem_pkt::*;
#(
  parameter int WAIT_RD  = 4,
  parameter int WDOG_CYC = 8191
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_sop,
  input  logic        in_valid,
  input  logic        in_eop,
  output logic        in_ready,
  input  nf_vec_t     Nf,
  input  logic [11:0] dftpts,
  input  logic        rd_end,
  input  logic        wr_end,
  input  logic        source_end,
  output logic [2:0]  fsm,
  output logic [2:0]  fsm_r,
  output logic [2:0]  stage_idx,
  output logic        rd_start,
  output logic        frame_err,
  output logic        wdog_to
);

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_RD - 1);

  state_t             state;
  nf_vec_t            nf_q;
  logic [9:0]         exp_beats;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [BEAT_W-1:0]  beat_inc;
  logic [7:0]         wait_cnt;
  nstage_t            n_stg;
  logic               wd_hit;
  logic               unused_dft;

  // Beat length is counted in 4-sample beats, so the two LSBs never matter.
  assign unused_dft = ^dftpts[1:0];

  mrd_nstage_cnt u_nstage (
    .nf    (nf_q),
    .n_stg (n_stg)
  );

  assign beat_inc = (beat_cnt == {BEAT_W{1'b1}}) ? beat_cnt : beat_cnt + 1'b1;
  assign fsm      = state;
  assign in_ready = (state == S_IDLE) || (state == S_SINK);

`ifdef MRD_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            leave;

  // Mirrors the exit conditions of the FSM so the counter restarts on every state change.
  always_comb begin
    leave = 1'b0;
    case (state)
      S_SINK:    leave = in_valid && in_eop;
      S_WAIT_RD: leave = (wait_cnt == WAIT_LAST);
      S_RD:      leave = rd_end;
      S_WAIT_WR: leave = wr_end;
      S_SOURCE:  leave = source_end;
      default:   leave = 1'b0;
    endcase
  end

  // Fires on the WDOG_CYC-th consecutive cycle spent in one non-Idle state.
  assign wd_hit = (state != S_IDLE) && (wd_cnt == WD_W'(WDOG_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      wdog_to <= 1'b0;
    end else begin
      wdog_to <= wd_hit;
      if ((state == S_IDLE) || leave || wd_hit) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_wdog;

  assign unused_wdog = (WDOG_CYC == 0);
  assign wd_hit      = 1'b0;
  assign wdog_to     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      stage_idx <= '0;
      rd_start  <= 1'b0;
      frame_err <= 1'b0;
      beat_cnt  <= '0;
      wait_cnt  <= '0;
      nf_q      <= '0;
      exp_beats <= '0;
    end else begin
      rd_start <= 1'b0;
      if (wd_hit) begin
        state     <= S_IDLE;
        stage_idx <= '0;
        frame_err <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (in_sop && in_valid) begin
              state     <= S_SINK;
              nf_q      <= Nf;
              exp_beats <= dftpts[11:2];
              beat_cnt  <= BEAT_W'(1);
              frame_err <= 1'b0;
            end
          end
          // A second sop inside the frame is just another beat.
          S_SINK: begin
            if (in_valid) begin
              beat_cnt <= beat_inc;
              if (in_eop) begin
                wait_cnt <= '0;
                // Length mismatch is flagged but the frame still runs.
                if ((beat_inc != {2'b00, exp_beats}) || (n_stg == '0)) begin
                  frame_err <= 1'b1;
                end
                state <= (n_stg == '0) ? S_SOURCE : S_WAIT_RD;
              end
            end
          end
          S_WAIT_RD: begin
            if (wait_cnt == WAIT_LAST) begin
              state    <= S_RD;
              rd_start <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          // wr_end arriving with rd_end is dropped: the write-back it reports is not yet awaited.
          S_RD: begin
            if (rd_end) begin
              state <= S_WAIT_WR;
            end
          end
          S_WAIT_WR: begin
            if (wr_end) begin
              if (stage_idx == n_stg - nstage_t'(1)) begin
                state <= S_SOURCE;
              end else begin
                stage_idx <= stage_idx + 1'b1;
                wait_cnt  <= '0;
                state     <= S_WAIT_RD;
              end
            end
          end
          S_SOURCE: begin
            if (source_end) begin
              state     <= S_IDLE;
              stage_idx <= '0;
            end
          end
          default: begin
            state     <= S_IDLE;
            stage_idx <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r <= 3'd0;
    end else begin
      fsm_r <= state;
    end
  end

endmodule
